// File: rtl/counter_modulo_if.sv
// Signal bundle for counter_modulo: control/data inputs and registered outputs.
// The presc field exists only when COUNTER_PRESCALE_EN is defined.
interface counter_modulo_if #(
  parameter int COUNT_W = 16,
  parameter int PRE_W   = 8
);
  logic               en;
  logic               up_dn;
  logic               load;
  logic [COUNT_W-1:0] load_val;
  logic [COUNT_W-1:0] limit;
`ifdef COUNTER_PRESCALE_EN
  logic [PRE_W-1:0]   presc;
`endif
  logic [COUNT_W-1:0] count;
  logic               overflow;
  logic               underflow;

  modport master (
    output en, up_dn, load, load_val, limit,
`ifdef COUNTER_PRESCALE_EN
    output presc,
`endif
    input  count, overflow, underflow
  );

  modport slave (
    input  en, up_dn, load, load_val, limit,
`ifdef COUNTER_PRESCALE_EN
    input  presc,
`endif
    output count, overflow, underflow
  );
endinterface

// File: rtl/counter_modulo.sv
// Up/down modulo counter (0..limit) with wrap or saturate boundaries and load.
// Optional prescaler compiled in with macro COUNTER_PRESCALE_EN.
module counter_modulo #(
  parameter int COUNT_W = 16,
  parameter int MODE    = 0,
  parameter int PRE_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  counter_modulo_if.slave bus
);

  if (COUNT_W < 2 || COUNT_W > 32 || PRE_W < 1 || MODE < 0 || MODE > 1) begin : g_param_check
    $error("counter_modulo: illegal parameter value");
  end

  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               tick;

`ifdef COUNTER_PRESCALE_EN
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic               presc_hit;

  // >= rather than == so a divisor lowered mid-run cannot strand the prescaler.
  assign presc_hit = (presc_q >= bus.presc);
  assign tick      = bus.en && presc_hit;

  always_comb begin
    presc_d = presc_q;
    if (bus.load) begin
      presc_d = '0;
    end else if (bus.en) begin
      presc_d = presc_hit ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = bus.en;
`endif

  always_comb begin
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    end else if (tick) begin
      if (bus.up_dn) begin
        if (count_q < bus.limit) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d    = (MODE == 1) ? bus.limit : '0;
          overflow_d = 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d     = (MODE == 1) ? '0 : bus.limit;
          underflow_d = 1'b1;
        end else if (count_q > bus.limit) begin
          // Limit was lowered under a running count: clamp silently.
          count_d = bus.limit;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_counter_modulo.sv
// Directed bench: wrap-mode and saturate-mode counters side by side (COUNT_W=8).
module tb_counter_modulo;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  counter_modulo_if #(.COUNT_W(8), .PRE_W(8)) bus0 ();
  counter_modulo_if #(.COUNT_W(8), .PRE_W(8)) bus1 ();

  counter_modulo #(.COUNT_W(8), .MODE(0), .PRE_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  counter_modulo #(.COUNT_W(8), .MODE(1), .PRE_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk0(input string tag, input logic [7:0] c, input logic o, input logic u);
    chk({tag, ".count"}, 32'(bus0.count), 32'(c));
    chk({tag, ".ovf"}, 32'(bus0.overflow), 32'(o));
    chk({tag, ".unf"}, 32'(bus0.underflow), 32'(u));
    $display("t=%0t dut0 %s count=%0d ovf=%0d unf=%0d", $time, tag, bus0.count, bus0.overflow, bus0.underflow);
  endtask

  task automatic chk1(input string tag, input logic [7:0] c, input logic o, input logic u);
    chk({tag, ".count"}, 32'(bus1.count), 32'(c));
    chk({tag, ".ovf"}, 32'(bus1.overflow), 32'(o));
    chk({tag, ".unf"}, 32'(bus1.underflow), 32'(u));
    $display("t=%0t dut1 %s count=%0d ovf=%0d unf=%0d", $time, tag, bus1.count, bus1.overflow, bus1.underflow);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus0.en = 1'b0; bus0.up_dn = 1'b1; bus0.load = 1'b0; bus0.load_val = 8'd0; bus0.limit = 8'd9;
    bus1.en = 1'b0; bus1.up_dn = 1'b1; bus1.load = 1'b0; bus1.load_val = 8'd0; bus1.limit = 8'd200;
`ifdef COUNTER_PRESCALE_EN
    bus0.presc = 8'd0;
    bus1.presc = 8'd0;
`endif
    #1;
    chk0("reset0", 8'd0, 1'b0, 1'b0);
    chk1("reset1", 8'd0, 1'b0, 1'b0);
    cyc(2);
    rst = 1'b0;

    // Load 5, then assert reset mid-period: clears before the next edge.
    bus0.load = 1'b1; bus0.load_val = 8'd5;
    cyc(1);
    bus0.load = 1'b0;
    chk0("load5", 8'd5, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk0("async_rst", 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Wrap up, limit 9.
    bus0.en = 1'b1; bus0.up_dn = 1'b1;
    cyc(9);
    chk0("up9", 8'd9, 1'b0, 1'b0);
    cyc(1);
    chk0("up10_wrap", 8'd0, 1'b1, 1'b0);
    cyc(1);
    chk0("up11", 8'd1, 1'b0, 1'b0);
    cyc(9);
    chk0("up20_wrap", 8'd0, 1'b1, 1'b0);
    bus0.en = 1'b0;
    cyc(1);
    chk0("hold", 8'd0, 1'b0, 1'b0);

    // Wrap down from 0.
    bus0.en = 1'b1; bus0.up_dn = 1'b0;
    cyc(1);
    chk0("dn_wrap", 8'd9, 1'b0, 1'b1);
    cyc(3);
    chk0("dn3", 8'd6, 1'b0, 1'b0);
    bus0.en = 1'b0;

    // Saturate mode at limit 200.
    bus1.load = 1'b1; bus1.load_val = 8'd200;
    cyc(1);
    bus1.load = 1'b0;
    chk1("sat_load", 8'd200, 1'b0, 1'b0);
    bus1.en = 1'b1; bus1.up_dn = 1'b1;
    cyc(1);
    chk1("sat_up1", 8'd200, 1'b1, 1'b0);
    cyc(1);
    chk1("sat_up2", 8'd200, 1'b1, 1'b0);
    cyc(1);
    chk1("sat_up3", 8'd200, 1'b1, 1'b0);
    bus1.en = 1'b0;
    cyc(1);
    chk1("sat_idle", 8'd200, 1'b0, 1'b0);
    bus1.load = 1'b1; bus1.load_val = 8'd250;
    cyc(1);
    chk1("sat_load250", 8'd200, 1'b0, 1'b0);
    bus1.load_val = 8'd0;
    cyc(1);
    bus1.load = 1'b0;
    bus1.en = 1'b1; bus1.up_dn = 1'b0;
    cyc(1);
    chk1("sat_dn0", 8'd0, 1'b0, 1'b1);
    bus1.en = 1'b0;
    cyc(1);
    chk1("sat_dn_idle", 8'd0, 1'b0, 1'b0);

    // Load beats tick; then lowered limit clamps on a down tick.
    bus0.load = 1'b1; bus0.load_val = 8'd4;
    cyc(1);
    chk0("load4", 8'd4, 1'b0, 1'b0);
    bus0.load_val = 8'd7; bus0.en = 1'b1; bus0.up_dn = 1'b1;
    cyc(1);
    chk0("load_vs_tick", 8'd7, 1'b0, 1'b0);
    bus0.load = 1'b0; bus0.limit = 8'd3; bus0.up_dn = 1'b0;
    cyc(1);
    chk0("clamp_dn", 8'd3, 1'b0, 1'b0);
    cyc(1);
    chk0("dn_after_clamp", 8'd2, 1'b0, 1'b0);
    bus0.en = 1'b0;

    // limit = 0 in wrap mode.
    bus0.limit = 8'd0; bus0.load = 1'b1; bus0.load_val = 8'd0;
    cyc(1);
    bus0.load = 1'b0; bus0.en = 1'b1; bus0.up_dn = 1'b1;
    cyc(1);
    chk0("lim0_up1", 8'd0, 1'b1, 1'b0);
    cyc(1);
    chk0("lim0_up2", 8'd0, 1'b1, 1'b0);
    bus0.up_dn = 1'b0;
    cyc(1);
    chk0("lim0_dn", 8'd0, 1'b0, 1'b1);
    bus0.en = 1'b0;

    // Free-running binary counter with limit all-ones.
    bus0.limit = 8'd255; bus0.load = 1'b1; bus0.load_val = 8'd254;
    cyc(1);
    bus0.load = 1'b0; bus0.en = 1'b1; bus0.up_dn = 1'b1;
    cyc(1);
    chk0("free_255", 8'd255, 1'b0, 1'b0);
    cyc(1);
    chk0("free_wrap", 8'd0, 1'b1, 1'b0);
    bus0.en = 1'b0;

`ifdef COUNTER_PRESCALE_EN
    // Divide by 4; an en gap of 2 cycles delays the next step by 2.
    bus0.limit = 8'd9; bus0.presc = 8'd3; bus0.load = 1'b1; bus0.load_val = 8'd0;
    cyc(1);
    bus0.load = 1'b0; bus0.en = 1'b1; bus0.up_dn = 1'b1;
    cyc(3);
    chk0("pre_c3", 8'd0, 1'b0, 1'b0);
    cyc(1);
    chk0("pre_c4", 8'd1, 1'b0, 1'b0);
    cyc(3);
    chk0("pre_c7", 8'd1, 1'b0, 1'b0);
    cyc(1);
    chk0("pre_c8", 8'd2, 1'b0, 1'b0);
    bus0.en = 1'b0;
    cyc(2);
    chk0("pre_gap", 8'd2, 1'b0, 1'b0);
    bus0.en = 1'b1;
    cyc(3);
    chk0("pre_after_gap3", 8'd2, 1'b0, 1'b0);
    cyc(1);
    chk0("pre_after_gap4", 8'd3, 1'b0, 1'b0);
    bus0.en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_modulo.md
COUNTER_MODULO -- requirements
Module: counter_modulo

Interface
REQ-001 Parameter COUNT_W, default 16: counter width in bits, legal range 2..32.
REQ-002 Parameter MODE, default 0: 0 means wrap at boundaries, 1 means saturate at boundaries.
REQ-003 Parameter PRE_W, default 8: prescaler width in bits. Used only when COUNTER_PRESCALE_EN is defined.
REQ-004 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 en  input  1  count enable. 1 means step this cycle (subject to the prescaler).
REQ-007 up_dn  input  1  direction. 1 = count up, 0 = count down.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  COUNT_W  value loaded when load=1.
REQ-010 limit  input  COUNT_W  modulo limit. Count range is 0..limit inclusive; sampled every cycle.
REQ-011 presc  input  PRE_W  prescale divisor minus 1. Present only when COUNTER_PRESCALE_EN is defined.
REQ-012 count  output  COUNT_W  registered counter value.
REQ-013 overflow  output  1  registered one-cycle pulse on an up-step at the limit.
REQ-014 underflow  output  1  registered one-cycle pulse on a down-step at 0.

Function
REQ-015 Every edge where the step condition holds is a "tick". The step condition is en=1, plus the prescaler condition when one is compiled in.
REQ-016 Priority per edge is rst > load > tick > hold.
REQ-017 Load: count <= min(load_val, limit). overflow and underflow are 0 the next cycle. Any en/tick in the same cycle is ignored.
REQ-018 Up tick with count < limit: count <= count+1.
REQ-019 Up tick with count >= limit:
- MODE 0: count <= 0.
- MODE 1: count <= limit.
- Both modes: overflow <= 1.
REQ-020 Down tick with 0 < count <= limit: count <= count-1.
REQ-021 Down tick with count > limit (limit lowered mid-run): count <= limit. No pulse.
REQ-022 Down tick with count = 0:
- MODE 0: count <= limit.
- MODE 1: count <= 0.
- Both modes: underflow <= 1.
REQ-023 overflow and underflow are 0 on every edge that is not the qualifying tick. They are never both 1.
REQ-024 No tick: count holds its value, and overflow and underflow return to 0.
REQ-025 limit=0:
- MODE 0, up tick: count stays 0 and overflow pulses every tick.
- MODE 0, down tick: count stays 0 and underflow pulses every tick.
REQ-026 All arithmetic is modulo 2^COUNT_W internally. With limit=all-ones, MODE 0 behaves as a free-running binary counter.
REQ-027 Latency: count, overflow and underflow reflect a tick or load one clock after the sampling edge.

Reset
REQ-028 rst=1 immediately and asynchronously forces count=0, overflow=0, underflow=0, and the prescaler counter to 0, independent of clk.
REQ-029 Deassertion of rst takes effect at the next edge. The first tick may occur on the first edge with rst=0.
REQ-030 rst asserted mid-count or mid-prescale discards all state. There is no resume.

Configuration
REQ-031 Macro COUNTER_PRESCALE_EN defined:
- An internal PRE_W-bit prescaler counter advances on each edge with en=1.
- A tick occurs only when prescaler = presc, after which the prescaler clears to 0.
- en=0 holds the prescaler.
- load clears the prescaler.
- presc=0 gives a tick on every enabled cycle.
REQ-032 Macro COUNTER_PRESCALE_EN undefined: the presc port and the prescaler logic are absent, and every edge with en=1 is a tick.

Verification
REQ-033 Reset check: assert rst mid-clock-period with count=5 -> count=0, overflow=0 and underflow=0 before the next clk edge.
REQ-034 Wrap up (COUNT_W=8, MODE 0, limit=9, en=1, up_dn=1): count=9 after 9 ticks; the 10th tick gives count=0 and overflow=1 for exactly one cycle; count=10%10 after 20 ticks.
REQ-035 Wrap down (MODE 0, limit=9, count=0): down tick -> count=9 and underflow=1 for one cycle; 3 more ticks -> count=6 and underflow=0.
REQ-036 Saturate (MODE 1, limit=200): count=200, 3 up ticks -> count stays 200 and overflow=1 on each of those 3 cycles; load_val=250 -> count=200.
REQ-037 Load and tick collision (limit=9, count=4): load=1, load_val=7, en=1 the same cycle -> count=7, no step. Limit lowered to 3 with count=7, down tick -> count=3.
REQ-038 With COUNTER_PRESCALE_EN (presc=3, limit=9, en=1): count increments once every 4 clocks. Dropping en for 2 cycles delays the next increment by exactly 2 clocks.
